ssc_corr_event_ctrl: RTL

Downstream collector for the eight spread-spectrum correlator channels. It edge-detects each channel's correlation-seen flag and holds the sticky CorrelationSeen register at 0x108. It queues time-stamped correlation events in a FIFO for host polling, drives a registered interrupt, and merges the eight channel read buses with its own registers into the single host read bus.

---
 rtl/ssc_corr_event_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ssc_corr_event_ctrl.sv
// rtl/ssc_corr_event_ctrl.sv - correlator event collector: sticky seen flags, time-stamped event FIFO, irq, read-bus merge
module ssc_corr_event_ctrl #(
  parameter int NCH        = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TS_W       = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       Wdata,
  input  logic              write,
  input  logic              read,
  input  logic              pushADC,
  input  logic              Global_Run,
  input  logic [32*NCH-1:0] Rdata_ch,
  input  logic [NCH-1:0]    cseen,
  output logic [31:0]       Rdata,
  output logic              irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 3 + TS_W;

  logic [NCH-1:0]  seen, pend, cseen_q;
  logic [NCH:0]    ien;
  logic [TS_W-1:0] ts;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            ovf;
  logic            read_q;
  logic [15:0]     addr_q;
  logic [EW-1:0]   mem [FIFO_DEPTH];

  logic [15:0]     a;
  logic            first, sel_seen, sel_evt, sel_stat, sel_ien, sel_ts;
  logic            pop, push, push_ok, full;
  logic [NCH-1:0]  rise, pr, grant, clr;
  logic [2:0]      gidx;
  logic [EW-1:0]   head;
  logic [31:0]     ch_or, own;
  logic            unused_bits;

  assign unused_bits = ^{addr[31:16], Wdata[30:TS_W]};

  assign a        = addr[15:0];
  assign sel_seen = (a == 16'h0108);
  assign sel_evt  = (a == 16'h010C);
  assign sel_stat = (a == 16'h0110);
  assign sel_ien  = (a == 16'h0114);
  assign sel_ts   = (a == 16'h0118);

  // A read held on the same address is one access; side effects fire only in its first cycle.
  assign first = read && !(read_q && (addr_q == a));
  assign pop   = first && sel_evt && (count != '0);
  assign clr   = (first && sel_seen) ? '1 : '0;

  assign rise    = cseen & ~cseen_q;
  assign pr      = pend | rise;
  assign grant   = pr & (~pr + 1'b1);
  assign push    = |pr;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign push_ok = push && (!full || pop);
  assign head    = mem[rd_ptr];

  always_comb begin
    gidx = 3'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pr[i]) gidx = 3'(i);
    end
  end

  always_comb begin
    ch_or = 32'h0;
    for (int i = 0; i < NCH; i++) begin
      ch_or = ch_or | Rdata_ch[32*i +: 32];
    end
  end

  always_comb begin
    own = 32'h0;
    if (sel_seen) own = 32'(seen);
    if (sel_evt && (count != '0)) own = {1'b1, 4'b0, head[EW-1:TS_W], head[TS_W-1:0]};
    if (sel_stat) own = {ovf, {(31-CW){1'b0}}, count};
    if (sel_ien)  own = 32'(ien);
    if (sel_ts)   own = 32'(ts);
  end

  assign Rdata = read ? (ch_or | own) : 32'h0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {gidx, ts};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seen    <= '0;
      pend    <= '0;
      cseen_q <= '0;
      ien     <= '0;
      ts      <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      read_q  <= 1'b0;
      addr_q  <= '0;
      irq     <= 1'b0;
    end else begin
      cseen_q <= cseen;
      read_q  <= read;
      addr_q  <= a;
      seen    <= (seen & ~clr) | rise;
      pend    <= pr & ~grant;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
      // Overflow set beats a same-cycle host clear.
      if (push && full && !pop)                 ovf <= 1'b1;
      else if (write && sel_stat && Wdata[31])  ovf <= 1'b0;
      if (write && sel_ien) ien <= Wdata[NCH:0];
      if (write && sel_ts)                ts <= Wdata[TS_W-1:0];
      else if (pushADC && Global_Run)     ts <= ts + 1'b1;
      irq <= (|(seen & ien[NCH-1:0])) | (ien[NCH] && (count != '0));
    end
  end
endmodule
